// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: command layout, width codes, FSM states and beat helpers
package spi_bridge_pkg;
  localparam int CMD_RW = 7;
  localparam int CMD_W_HI = 6;
  localparam int CMD_W_LO = 5;
  localparam int CMD_INC = 4;
  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;
  localparam logic [1:0] WIDTH_ILL = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR_SHIFT, S_WR_STROBE, S_RD_REQ, S_RD_WAIT, S_RD_SHIFT, S_IGNORE
  } state_t;
  function automatic logic [2:0] beat_bytes(input logic [1:0] w);
    return w == WIDTH_W ? 3'd4 : w == WIDTH_H ? 3'd2 : 3'd1;
  endfunction
  function automatic logic [31:0] lane_mask(input logic [1:0] w, input logic [31:0] d);
    return w == WIDTH_W ? d : w == WIDTH_H ? {16'b0, d[15:0]} : {24'b0, d[7:0]};
  endfunction
endpackage

// File: rtl/synchronizer.sv
// synchronizer: multi-flop synchronizer for asynchronous inputs
module synchronizer #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] ff [STAGES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= RST_VAL;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_periph_bridge.sv
// spi_periph_bridge: SPI mode-0 slave bridging byte/half/word bursts onto the
// TinyQV peripheral bus, with read wait/timeout and lane masking.
module spi_periph_bridge import spi_bridge_pkg::*; #(
  parameter int          ADDR_W         = 6,
  parameter int          SYNC_STAGES    = 2,
  parameter int          RD_TIMEOUT     = 255,
  parameter logic [31:0] RD_TIMEOUT_VAL = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [31:0]       data_out,
  input  logic              data_ready,
  output logic              busy,
  output logic              err
);
  logic cs_s, sclk_s, mosi_s, cs_d, sclk_d;
  synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));
  synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_clk), .q(sclk_s));
  synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_d   <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      cs_d   <= cs_s;
      sclk_d <= sclk_s;
    end
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  state_t      state;
  logic [31:0] shreg;
  logic [5:0]  bit_cnt;
  logic [9:0]  tmo;
  logic [1:0]  width;
  logic        rw, inc;
  logic [31:0] sh_next, rd_word;
  logic [2:0]  nbytes;
  logic [5:0]  last_bit;
  logic        last;
  assign sh_next  = {shreg[30:0], mosi_s};
  assign nbytes   = beat_bytes(width);
  assign last_bit = (state == S_CMD || state == S_ADDR) ? 6'd7 : {nbytes, 3'b000} - 6'd1;
  assign last     = bit_cnt == last_bit;
  // Read data is left-aligned so MISO always shifts out of bit 31.
  assign rd_word  = lane_mask(width, data_ready ? data_out : RD_TIMEOUT_VAL)
                    << {3'(3'd4 - nbytes), 3'b000};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      tmo          <= '0;
      width        <= WIDTH_B;
      rw           <= 1'b0;
      inc          <= 1'b0;
      spi_miso     <= 1'b0;
      address      <= '0;
      data_in      <= '0;
      data_write_n <= WIDTH_ILL;
      data_read_n  <= WIDTH_ILL;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else if (cs_rise) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      spi_miso     <= 1'b0;
      data_write_n <= WIDTH_ILL;
      data_read_n  <= WIDTH_ILL;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) begin
          state   <= S_CMD;
          bit_cnt <= '0;
          busy    <= 1'b1;
          err     <= 1'b0;
        end
        S_CMD: if (sclk_rise) begin
          shreg   <= sh_next;
          bit_cnt <= bit_cnt + 6'd1;
          if (last) begin
            bit_cnt <= '0;
            rw      <= sh_next[CMD_RW];
            width   <= sh_next[CMD_W_HI:CMD_W_LO];
            inc     <= sh_next[CMD_INC];
            state   <= sh_next[CMD_W_HI:CMD_W_LO] == WIDTH_ILL ? S_IGNORE : S_ADDR;
            if (sh_next[CMD_W_HI:CMD_W_LO] == WIDTH_ILL) err <= 1'b1;
          end
        end
        S_ADDR: if (sclk_rise) begin
          shreg   <= sh_next;
          bit_cnt <= bit_cnt + 6'd1;
          if (last) begin
            bit_cnt <= '0;
            address <= sh_next[ADDR_W-1:0];
            state   <= rw ? S_WR_SHIFT : S_RD_REQ;
            if (!rw) data_read_n <= width;
          end
        end
        S_WR_SHIFT: if (sclk_rise) begin
          shreg   <= sh_next;
          bit_cnt <= bit_cnt + 6'd1;
          if (last) begin
            bit_cnt      <= '0;
            data_in      <= lane_mask(width, sh_next);
            data_write_n <= width;
            state        <= S_WR_STROBE;
          end
        end
        S_WR_STROBE: begin
          data_write_n <= WIDTH_ILL;
          state        <= S_WR_SHIFT;
          if (inc) address <= address + ADDR_W'(nbytes);
        end
        S_RD_REQ: begin
          state <= S_RD_WAIT;
          tmo   <= '0;
        end
        S_RD_WAIT:
          if (data_ready || tmo == 10'(RD_TIMEOUT - 1)) begin
            shreg       <= rd_word;
            data_read_n <= WIDTH_ILL;
            bit_cnt     <= '0;
            state       <= S_RD_SHIFT;
            if (!data_ready) err <= 1'b1;
            if (inc) address <= address + ADDR_W'(nbytes);
          end else tmo <= tmo + 10'd1;
        S_RD_SHIFT: begin
          if (sclk_fall) begin
            spi_miso <= shreg[31];
            shreg    <= shreg << 1;
          end
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (last) begin
              bit_cnt     <= '0;
              spi_miso    <= 1'b0;
              data_read_n <= width;
              state       <= S_RD_REQ;
            end
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_spi_periph_bridge.sv
// tb_spi_periph_bridge: directed checks of writes, read bursts, wait/timeout,
// abort, illegal width and asynchronous reset.
`timescale 1ns/1ps
module tb_spi_periph_bridge;
  localparam int HALF = 8;
  logic clk = 1'b0, rst_n = 1'b0, spi_cs_n = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, busy, err, data_ready = 1'b0;
  logic [5:0] address;
  logic [31:0] data_in, data_out = 32'h1234_56AA;
  logic [1:0] data_write_n, data_read_n;
  int errors = 0, checks = 0;
  int wr_cnt = 0, ready_lat = 0, req_cyc = 0, req_n = 0;
  logic [31:0] wr_data = '0;
  logic [5:0]  wr_addr = '0;
  logic [1:0]  wr_w = '0;
  logic [5:0]  req_addr [8];
  logic [1:0]  req_w [8];
  int          req_len [8];

  always #5 clk = ~clk;

  spi_periph_bridge dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready), .busy(busy), .err(err));

  // Peripheral model: logs strobes/requests and answers reads after ready_lat cycles.
  always @(negedge clk) begin
    if (data_write_n != 2'b11) begin
      wr_cnt++;
      wr_data = data_in;
      wr_addr = address;
      wr_w = data_write_n;
    end
    if (data_read_n != 2'b11) begin
      if (req_cyc == 0 && req_n < 8) begin
        req_addr[req_n] = address;
        req_w[req_n] = data_read_n;
        req_len[req_n] = 0;
        req_n++;
      end
      req_cyc++;
      data_ready = ready_lat >= 0 && req_cyc > ready_lat;
    end else begin
      if (req_cyc != 0 && req_n > 0) req_len[req_n-1] = req_cyc;
      req_cyc = 0;
      data_ready = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_miso"}, 32'(spi_miso), 32'd0);
    chk({p, "_address"}, 32'(address), 32'd0);
    chk({p, "_data_in"}, data_in, 32'd0);
    chk({p, "_write_n"}, 32'(data_write_n), 32'd3);
    chk({p, "_read_n"}, 32'(data_read_n), 32'd3);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // MSB-first transfer; miso is sampled just before each rising edge and
  // gap extra clocks are held before the final falling edge.
  task automatic xfer(input logic [31:0] tx, input int nbits, input int gap, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      spi_mosi = tx[i];
      wait_clk(HALF);
      @(negedge clk);
      rx = {rx[30:0], spi_miso};
      spi_clk = 1'b1;
      wait_clk(HALF);
      if (i == 0) wait_clk(gap);
      @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low;
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high;
    wait_clk(HALF);
    @(negedge clk);
    spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  initial begin
    logic [31:0] rx;
    int n;
    wait_clk(3);
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(4);

    wr_cnt = 0;
    cs_low;
    chk("busy_in_frame", 32'(busy), 32'd1);
    xfer(32'hC0, 8, 0, rx);
    xfer(32'h05, 8, 0, rx);
    xfer(32'hDEAD_BEEF, 32, 0, rx);
    cs_high;
    chk("wr_word_strobes", wr_cnt, 1);
    chk("wr_word_width", 32'(wr_w), 32'd2);
    chk("wr_word_addr", 32'(wr_addr), 32'h05);
    chk("wr_word_data", wr_data, 32'hDEAD_BEEF);
    chk("busy_after_frame", 32'(busy), 32'd0);

    ready_lat = 0;
    req_n = 0;
    cs_low;
    xfer(32'h10, 8, 0, rx);
    xfer(32'h3E, 8, 20, rx);
    for (int b = 0; b < 3; b++) begin
      xfer(32'h00, 8, 20, rx);
      chk("burst_miso", rx, 32'hAA);
    end
    cs_high;
    chk("burst_addr0", 32'(req_addr[0]), 32'h3E);
    chk("burst_addr1", 32'(req_addr[1]), 32'h3F);
    chk("burst_addr2_wrap", 32'(req_addr[2]), 32'h00);
    chk("burst_width", 32'(req_w[0]), 32'd0);

    ready_lat = 40;
    req_n = 0;
    cs_low;
    xfer(32'h20, 8, 0, rx);
    xfer(32'h07, 8, 100, rx);
    xfer(32'h0000, 16, 20, rx);
    cs_high;
    chk("half_miso", rx, 32'h56AA);
    chk("half_width", 32'(req_w[0]), 32'd1);
    chk("half_hold_len", req_len[0], 41);
    chk("half_err", 32'(err), 32'd0);

    ready_lat = -1;
    req_n = 0;
    cs_low;
    xfer(32'h40, 8, 0, rx);
    xfer(32'h01, 8, 300, rx);
    xfer(32'h0, 32, 20, rx);
    cs_high;
    chk("tmo_miso", rx, 32'hFFFF_FFFF);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_hold_len", req_len[0], 256);
    cs_low;
    chk("tmo_err_cleared", 32'(err), 32'd0);
    cs_high;

    wr_cnt = 0;
    cs_low;
    xfer(32'hE0, 8, 0, rx);
    xfer(32'h05, 8, 0, rx);
    xfer(32'hAABB_CCDD, 32, 0, rx);
    cs_high;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_no_strobe", wr_cnt, 0);

    wr_cnt = 0;
    cs_low;
    xfer(32'hC0, 8, 0, rx);
    xfer(32'h09, 8, 0, rx);
    xfer(32'hABC, 12, 0, rx);
    cs_high;
    chk("abort_no_strobe", wr_cnt, 0);
    cs_low;
    xfer(32'h80, 8, 0, rx);
    xfer(32'h0A, 8, 0, rx);
    xfer(32'h5C, 8, 0, rx);
    cs_high;
    chk("post_abort_strobes", wr_cnt, 1);
    chk("post_abort_data", wr_data, 32'h0000_005C);
    chk("post_abort_width", 32'(wr_w), 32'd0);
    chk("post_abort_addr", 32'(wr_addr), 32'h0A);
    chk("post_abort_err", 32'(err), 32'd0);

    ready_lat = -1;
    req_n = 0;
    cs_low;
    xfer(32'h40, 8, 0, rx);
    xfer(32'h02, 8, 0, rx);
    n = 0;
    while (data_read_n !== 2'b10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rd_pending", 32'(data_read_n), 32'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    spi_cs_n = 1'b1;
    wait_clk(4);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
